// File: rtl/gsim_mem_responder_pkg.sv
// Shared defaults, throttle mode encodings and LFSR step function for the
// GSIM matrix-memory read responder.
package gsim_mem_responder_pkg;

    localparam int unsigned AW_DEF  = 10;
    localparam int unsigned DW_DEF  = 256;
    localparam int unsigned LAT_DEF = 2;
    localparam int unsigned LAT_MAX = 4;
    localparam logic [15:0] SEED_DEF = 16'hACE1;

    typedef enum logic [1:0] {
        MODE_ALWAYS   = 2'd0,
        MODE_RANDOM   = 2'd1,
        MODE_PERIODIC = 2'd2,
        MODE_HOLD     = 2'd3
    } mode_e;

    // Fibonacci step, taps 16,14,13,11, shifting toward bit 0.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

endpackage

// File: rtl/gsim_mem_responder_if.sv
// Read-request / row-response bus between the GSIM core and its memory responder.
interface gsim_mem_responder_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 256
);
    logic          mem_rreq;
    logic [AW-1:0] mem_addr;
    logic          mem_rrdy;
    logic [DW-1:0] mem_dout;
    logic          mem_dout_vld;

    modport master (
        output mem_rreq, mem_addr,
        input  mem_rrdy, mem_dout, mem_dout_vld
    );

    modport slave (
        input  mem_rreq, mem_addr,
        output mem_rrdy, mem_dout, mem_dout_vld
    );
endinterface

// File: rtl/gsim_lfsr16.sv
// 16-bit Fibonacci LFSR, loads the seed on reset and steps when enabled.
module gsim_lfsr16
    import gsim_mem_responder_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_seed,
    input  logic        i_en,
    output logic [15:0] o_state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (i_en) begin
            state_d = lfsr16_next(state_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= i_seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_state = state_q;

endmodule

// File: rtl/gsim_mem_responder.sv
// GSIM matrix-memory read responder: throttles requests, reads a 1-cycle SRAM and
// returns each accepted row a fixed LAT cycles later.
module gsim_mem_responder
    import gsim_mem_responder_pkg::*;
#(
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned LAT  = LAT_DEF,
    parameter logic [15:0] SEED = SEED_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [1:0]           i_mode,
    input  logic [3:0]           i_per_on,
    input  logic [3:0]           i_per_len,
    gsim_mem_responder_if.slave  mem,
    output logic                 o_ram_cen,
    output logic [AW-1:0]        o_ram_addr,
    input  logic [DW-1:0]        i_ram_q,
    output logic [15:0]          o_rd_cnt
);

    logic          rrdy_q, rrdy_d;
    logic [3:0]    phase_q, phase_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [LAT-1:0] vld_q, vld_d;
    logic [DW-1:0] dat_q [LAT];
    logic [DW-1:0] dat_d [LAT];
    logic          dout_vld_q, dout_vld_d;
    logic          accept;
    logic [3:0]    len_c;
    logic [15:0]   lfsr_state;
    logic          lfsr_unused;

    gsim_lfsr16 u_lfsr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_seed  (SEED),
        .i_en    (1'b1),
        .o_state (lfsr_state)
    );

    // Only bit 0 drives the random throttle.
    assign lfsr_unused = ^lfsr_state[15:1];

    assign accept = mem.mem_rreq & rrdy_q;
    assign len_c  = (i_per_len == 4'd0) ? 4'd1 : i_per_len;

    // Throttle: next-cycle ready from the current mode; phase idles at 0 outside periodic.
    always_comb begin
        rrdy_d  = 1'b1;
        phase_d = 4'd0;
        case (mode_e'(i_mode))
            MODE_ALWAYS: rrdy_d = 1'b1;
            MODE_RANDOM: rrdy_d = lfsr_state[0];
            MODE_PERIODIC: begin
                rrdy_d  = (phase_q < i_per_on) || (i_per_on >= len_c);
                phase_d = (phase_q >= 4'(len_c - 4'd1)) ? 4'd0 : 4'(phase_q + 4'd1);
            end
            MODE_HOLD:   rrdy_d = 1'b0;
            default:     rrdy_d = 1'b1;
        endcase
    end

    // Response pipe: each data stage only keeps a row when its valid bit says so.
    always_comb begin
        vld_d    = vld_q;
        vld_d[0] = accept;
        dat_d[0] = vld_q[0] ? i_ram_q : '0;
        for (int unsigned i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = vld_q[i] ? dat_q[i-1] : '0;
        end
        dout_vld_d = vld_q[LAT-1];
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && (cnt_q != 16'hFFFF)) begin
            cnt_d = 16'(cnt_q + 16'd1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rrdy_q     <= 1'b1;
            phase_q    <= 4'd0;
            cnt_q      <= 16'd0;
            vld_q      <= '0;
            dat_q      <= '{default: '0};
            dout_vld_q <= 1'b0;
        end else begin
            rrdy_q     <= rrdy_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            vld_q      <= vld_d;
            dat_q      <= dat_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    assign mem.mem_rrdy     = rrdy_q;
    assign mem.mem_dout     = dat_q[LAT-1];
    assign mem.mem_dout_vld = dout_vld_q;
    assign o_ram_cen        = accept;
    assign o_ram_addr       = mem.mem_addr;
    assign o_rd_cnt         = cnt_q;

endmodule

// File: tb/tb_gsim_mem_responder.sv
// Randomized bench for gsim_mem_responder: LAT=1/2/4 instances share stimulus and are
// compared each cycle against a cycle-count reference model.
module tb_gsim_mem_responder;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 256;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic [3:0]    per_on;
    logic [3:0]    per_len;
    logic          rreq;
    logic [AW-1:0] addr;

    always #5 clk = ~clk;

    gsim_mem_responder_if #(.AW(AW), .DW(DW)) bus1 ();
    gsim_mem_responder_if #(.AW(AW), .DW(DW)) bus2 ();
    gsim_mem_responder_if #(.AW(AW), .DW(DW)) bus4 ();

    assign bus1.mem_rreq = rreq;
    assign bus1.mem_addr = addr;
    assign bus2.mem_rreq = rreq;
    assign bus2.mem_addr = addr;
    assign bus4.mem_rreq = rreq;
    assign bus4.mem_addr = addr;

    logic          cen1, cen2, cen4;
    logic [AW-1:0] raddr1, raddr2, raddr4;
    logic [DW-1:0] rq1 = '0, rq2 = '0, rq4 = '0;
    logic [15:0]   cnt1, cnt2, cnt4;

    gsim_mem_responder #(.AW(AW), .DW(DW), .LAT(1), .SEED(SEED)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_mode(mode), .i_per_on(per_on), .i_per_len(per_len),
        .mem(bus1.slave), .o_ram_cen(cen1), .o_ram_addr(raddr1), .i_ram_q(rq1), .o_rd_cnt(cnt1));
    gsim_mem_responder #(.AW(AW), .DW(DW), .LAT(2), .SEED(SEED)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_mode(mode), .i_per_on(per_on), .i_per_len(per_len),
        .mem(bus2.slave), .o_ram_cen(cen2), .o_ram_addr(raddr2), .i_ram_q(rq2), .o_rd_cnt(cnt2));
    gsim_mem_responder #(.AW(AW), .DW(DW), .LAT(4), .SEED(SEED)) dut4 (
        .i_clk(clk), .i_reset(rst), .i_mode(mode), .i_per_on(per_on), .i_per_len(per_len),
        .mem(bus4.slave), .o_ram_cen(cen4), .o_ram_addr(raddr4), .i_ram_q(rq4), .o_rd_cnt(cnt4));

    // Row contents of the SRAM, a fixed function of the address.
    function automatic logic [DW-1:0] rowval(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        for (int w = 0; w < 8; w++) begin
            r[w*32 +: 32] = (32'(a) * 32'h9E3779B1) ^ (32'(w) << 24) ^ 32'h5A5A0000;
        end
        return r;
    endfunction

    always @(posedge clk) if (cen1) rq1 <= rowval(raddr1);
    always @(posedge clk) if (cen2) rq2 <= rowval(raddr2);
    always @(posedge clk) if (cen4) rq4 <= rowval(raddr4);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: ready per cycle plus a history of accepts indexed by edges ago.
    bit            m_rrdy;
    int unsigned   m_lfsr;
    int unsigned   m_t;
    int unsigned   m_cnt;
    bit            h_acc  [5];
    logic [AW-1:0] h_addr [5];

    task automatic model_edge();
        bit acc;
        int unsigned len, fb;
        if (rst) begin
            m_rrdy = 1'b1;
            m_lfsr = 32'(SEED);
            m_t    = 0;
            m_cnt  = 0;
            for (int j = 0; j < 5; j++) h_acc[j] = 1'b0;
        end else begin
            acc = rreq & m_rrdy;
            for (int j = 4; j > 0; j--) begin
                h_acc[j]  = h_acc[j-1];
                h_addr[j] = h_addr[j-1];
            end
            h_acc[0]  = acc;
            h_addr[0] = addr;
            if (acc && m_cnt != 65535) m_cnt++;
            case (mode)
                2'd0: m_rrdy = 1'b1;
                2'd1: m_rrdy = m_lfsr[0];
                2'd2: begin
                    len    = (per_len == 4'd0) ? 1 : int'(per_len);
                    m_rrdy = (m_t % len) < int'(per_on);
                    m_t++;
                end
                default: m_rrdy = 1'b0;
            endcase
            if (mode != 2'd2) m_t = 0;
            fb     = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
            m_lfsr = (m_lfsr >> 1) | (fb << 15);
        end
    endtask

    task automatic compare_all();
        int unsigned lats [3] = '{1, 2, 4};
        logic          vld_o  [3];
        logic [DW-1:0] dout_o [3];
        int unsigned   l;
        vld_o[0] = bus1.mem_dout_vld;  dout_o[0] = bus1.mem_dout;
        vld_o[1] = bus2.mem_dout_vld;  dout_o[1] = bus2.mem_dout;
        vld_o[2] = bus4.mem_dout_vld;  dout_o[2] = bus4.mem_dout;
        chk("rrdy", DW'(bus2.mem_rrdy), DW'(m_rrdy));
        chk("rrdy_l1", DW'(bus1.mem_rrdy), DW'(m_rrdy));
        chk("rrdy_l4", DW'(bus4.mem_rrdy), DW'(m_rrdy));
        chk("rd_cnt", DW'(cnt2), DW'(m_cnt));
        chk("rd_cnt_l4", DW'(cnt4), DW'(m_cnt));
        chk("ram_cen", DW'(cen2), DW'(rreq & m_rrdy));
        chk("ram_addr", DW'(raddr2), DW'(addr));
        for (int i = 0; i < 3; i++) begin
            l = lats[i];
            chk($sformatf("vld_lat%0d", l), DW'(vld_o[i]), DW'(h_acc[l]));
            chk($sformatf("dout_lat%0d", l), dout_o[i], h_acc[l] ? rowval(h_addr[l]) : '0);
        end
    endtask

    // One clock: inputs applied away from the edge, model stepped, outputs checked on negedge.
    task automatic step(input bit r, input bit q, input logic [AW-1:0] a);
        rst  = r;
        rreq = q;
        addr = a;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        mode = 2'd0; per_on = 4'd0; per_len = 4'd0;
        rst = 1'b1; rreq = 1'b0; addr = '0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("reset_rrdy", DW'(bus2.mem_rrdy), DW'(1'b1));
        chk("reset_cnt", DW'(cnt2), '0);

        // Always-ready burst of 16 rows.
        for (int a = 0; a < 16; a++) step(1'b0, 1'b1, AW'(a));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
        chk("burst_cnt", DW'(cnt2), DW'(16));

        // Periodic 1-of-3 with request held on one row.
        mode = 2'd2; per_on = 4'd1; per_len = 4'd3;
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, AW'(5));

        // Random throttle from a fresh seed.
        mode = 2'd0;
        step(1'b1, 1'b0, '0);
        mode = 2'd1;
        for (int i = 0; i < 1000; i++) step(1'b0, 1'b1, AW'($urandom));
        mode = 2'd0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);

        // Three accepts then hold-off while the request stays up.
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, AW'(11));
        step(1'b0, 1'b1, AW'(12));
        mode = 2'd3;
        step(1'b0, 1'b1, AW'(13));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, AW'($urandom));
        chk("hold_cnt", DW'(cnt2), DW'(3));

        // Reset with responses in flight.
        mode = 2'd0;
        step(1'b0, 1'b1, AW'(100));
        step(1'b0, 1'b1, AW'(101));
        step(1'b1, 1'b1, AW'(102));
        chk("rst_cnt", DW'(cnt2), '0);
        chk("rst_dout", bus2.mem_dout, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, AW'(7));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);

        // Alternating requests across all latencies.
        for (int i = 0; i < 40; i++) step(1'b0, 1'(i % 2 == 0), AW'($urandom));

        // Assorted periodic settings, including length 0 and on >= length.
        for (int k = 0; k < 6; k++) begin
            mode = 2'd0;
            step(1'b0, 1'b0, '0);
            mode = 2'd2;
            per_on  = 4'($urandom_range(0, 15));
            per_len = 4'($urandom_range(0, 15));
            if (k == 0) begin per_on = 4'd2; per_len = 4'd0; end
            if (k == 1) begin per_on = 4'd5; per_len = 4'd4; end
            for (int i = 0; i < 40; i++) step(1'b0, 1'($urandom_range(0, 3) != 0), AW'($urandom));
        end
        mode = 2'd0;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
